// File: rtl/fetch_unit.sv
// fetch_unit: PC register, credit-limited imem request/response handshake and a
// 2-entry in-order instruction queue with redirect-driven flush of stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  input  logic        inst_ready
);
  localparam logic [2:0] DEP = 3'(DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [31:0] fi_q [2];
  logic [31:0] fp_q [2];
  logic [31:0] sh_q [2];
  logic [1:0]  occ_q, occ_d, out_q, out_d, dis_q, dis_d;
  logic        rd_q, rd_d, wr_q, wr_d, run_q;
  logic        gnt, keep, pop, lvl;
  always_comb begin
    imem_req   = run_q && ({1'b0, occ_q} + {1'b0, out_q} < DEP);
    imem_addr  = run_q ? pc_q : '0;
    gnt        = imem_req && imem_gnt;
    keep       = imem_rvalid && dis_q == 2'd0 && !redirect;
    inst_valid = occ_q != 2'd0;
    pop        = inst_valid && inst_ready && !redirect;
    out_d      = out_q + {1'b0, gnt} - {1'b0, imem_rvalid};
    // On redirect every request still in flight after this cycle is stale
    dis_d      = redirect ? out_d : dis_q - {1'b0, imem_rvalid && dis_q != 2'd0};
    occ_d      = redirect ? 2'd0 : occ_q + {1'b0, keep} - {1'b0, pop};
    rd_d       = redirect ? 1'b0 : rd_q ^ pop;
    wr_d       = redirect ? 1'b0 : wr_q ^ keep;
    pc_d       = redirect ? (redirect_pc & 32'hFFFF_FFFC) : gnt ? pc_q + 32'd4 : pc_q;
    lvl        = out_q[0] && !imem_rvalid;
    inst       = inst_valid ? fi_q[rd_q] : '0;
    inst_pc    = inst_valid ? fp_q[rd_q] : '0;
    opcode     = inst[6:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      occ_q <= '0;
      out_q <= '0;
      dis_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      occ_q <= occ_d;
      out_q <= out_d;
      dis_q <= dis_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      run_q <= 1'b1;
    end
  end
  // PC-in-flight shadow: head is the PC of the oldest granted request
  always_ff @(posedge clk) begin
    if (imem_rvalid) sh_q[0] <= sh_q[1];
    if (gnt) sh_q[lvl] <= pc_q;
    if (keep) begin
      fi_q[wr_q] <= imem_rdata;
      fp_q[wr_q] <= sh_q[0];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory/consumer/redirect traffic checked against a
// queue-based transaction model of the fetch stream.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0;
  logic        redirect = 1'b0, inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic [6:0]  opcode;
  fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .inst_ready(inst_ready)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; bit stale; int due; } fl_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } fe_t;
  fl_t infl[$];
  fe_t fq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit started = 0;
  logic [31:0] m_pc = RPC;
  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  function automatic bit m_req();
    return started && (fq.size() + infl.size() < 2);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_outs();
    logic [31:0] d;
    chk("req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk("addr", imem_addr, m_pc);
    chk("valid", {31'b0, inst_valid}, {31'b0, fq.size() > 0});
    d = fq.size() > 0 ? fq[0].d : 32'h0;
    chk("inst", inst, d);
    chk("inst_pc", inst_pc, fq.size() > 0 ? fq[0].a : 32'h0);
    chk("opcode", {25'b0, opcode}, {25'b0, d[6:0]});
  endtask
  task automatic cycle(input bit g, input bit rdy, input bit rd, input logic [31:0] tgt, input int lat);
    bit req, rv, ge;
    fl_t e;
    req = m_req();
    rv  = infl.size() > 0 && infl[0].due <= cyc;
    imem_gnt = g; inst_ready = rdy; redirect = rd; redirect_pc = tgt;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_of(infl[0].addr) : $urandom;
    @(posedge clk); #1;
    ge = req && g;
    if (!rd && rdy && fq.size() > 0) void'(fq.pop_front());
    if (rv) begin
      e = infl.pop_front();
      if (!rd && !e.stale) fq.push_back('{a: e.addr, d: mem_of(e.addr)});
    end
    if (rd) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1;
    end
    if (ge) infl.push_back('{addr: m_pc, stale: rd, due: cyc + lat});
    m_pc = rd ? (tgt & 32'hFFFF_FFFC) : ge ? m_pc + 32'd4 : m_pc;
    started = 1;
    cyc++;
    imem_rvalid = 1'b0; redirect = 1'b0;
    check_outs();
  endtask
  initial begin
    bit seen;
    bit g, rdy, rd;
    logic [31:0] tgt;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0, 1);
      if (!seen && inst_valid) begin
        chk("first_lat", i + 1, 3);
        seen = 1;
      end
    end
    if (!seen) chk("first_lat", 0, 3);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1);
    chk("bp_req", {31'b0, imem_req}, 32'h0);
    chk("bp_full", {31'b0, inst_valid}, 32'h1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 2);
    cycle(1, 1, 1, 32'h0000_2003, 2);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 2);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (m_req() && infl.size() > 0 && infl[0].due <= cyc) begin
        cycle(1, 1, 1, 32'h0000_3000, 1);
        chk("sim_empty", {31'b0, inst_valid}, 32'h0);
        seen = 1;
      end else cycle(1, 1, 0, 0, 1);
    end
    if (!seen) chk("sim_found", 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    infl.delete(); fq.delete(); started = 0; m_pc = RPC;
    @(negedge clk) rst_n = 1'b1;
    cycle(1, 1, 0, 0, 1);
    chk("restart_addr", imem_addr, RPC);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      g   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      rd  = $urandom_range(0, 15) == 0;
      tgt = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(g, rdy, rd, tgt, $urandom_range(1, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
